// File: rtl/lpm_mux_elastic_pkg.sv
// Shared helpers for the elastic LPM mux: occupancy-width function and the
// elaboration-time parameter legality check.
`ifndef LPM_MUX_ELASTIC_PKG_SV
`define LPM_MUX_ELASTIC_PKG_SV

// Expands inside a module body; an illegal combination elaborates an $error.
`define LPM_CHECK_PARAMS(SIZE, WIDTHS, PIPE) \
  if (((SIZE) < 2) || ((2 ** (WIDTHS)) < (SIZE)) || ((PIPE) < 0)) begin : g_param_check \
    $error("lpm_mux_elastic: illegal LPM_SIZE/LPM_WIDTHS/LPM_PIPELINE combination"); \
  end

package lpm_mux_elastic_pkg;

  // Width of a 0..n counter, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`endif

// File: rtl/lpm_mux_elastic_if.sv
// Valid/ready bus of the elastic mux: producer side (data/sel) and consumer side (result).
interface lpm_mux_elastic_if
  import lpm_mux_elastic_pkg::*;
#(
  parameter int LPM_WIDTH    = 32,
  parameter int LPM_SIZE     = 4,
  parameter int LPM_WIDTHS   = 2,
  parameter int LPM_PIPELINE = 2
) ();

  localparam int OW = clog2_min1(LPM_PIPELINE);

  logic [LPM_SIZE*LPM_WIDTH-1:0] data;
  logic [LPM_WIDTHS-1:0]         sel;
  logic                          in_valid;
  logic                          in_ready;
  logic [LPM_WIDTH-1:0]          result;
  logic                          sel_err;
  logic                          out_valid;
  logic                          out_ready;
  logic [OW-1:0]                 occupancy;

  modport master (
    output data, sel, in_valid, out_ready,
    input  in_ready, result, sel_err, out_valid, occupancy
  );

  modport slave (
    input  data, sel, in_valid, out_ready,
    output in_ready, result, sel_err, out_valid, occupancy
  );

endinterface

// File: rtl/lpm_elastic_stage.sv
// One elastic pipeline slot: {valid, payload} register that loads whenever it
// is empty or its downstream neighbour is advancing.
module lpm_elastic_stage #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             clken,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_payload,
  input  logic             down_advance,
  output logic             valid,
  output logic [WIDTH-1:0] payload
);

  logic advance;

  assign advance = !valid || down_advance;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (clken && advance) begin
      valid   <= up_valid;
      payload <= up_payload;
    end
  end

endmodule

// File: rtl/lpm_mux_elastic.sv
// N-input W-bit multiplexer feeding an elastic valid/ready pipeline with
// bubble collapsing, out-of-range select flag and occupancy count.
module lpm_mux_elastic
  import lpm_mux_elastic_pkg::*;
#(
  parameter int                   LPM_WIDTH    = 32,
  parameter int                   LPM_SIZE     = 4,
  parameter int                   LPM_WIDTHS   = 2,
  parameter int                   LPM_PIPELINE = 2,
  parameter logic [LPM_WIDTH-1:0] OOR_VALUE    = '0
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clken,
  lpm_mux_elastic_if.slave  bus
);

  localparam int OW = clog2_min1(LPM_PIPELINE);
  localparam int PW = LPM_WIDTH + 1;

  `LPM_CHECK_PARAMS(LPM_SIZE, LPM_WIDTHS, LPM_PIPELINE)

  logic [LPM_WIDTH-1:0] mux_value;
  logic                 mux_err;

  always_comb begin
    mux_value = OOR_VALUE;
    mux_err   = 1'b1;
    for (int unsigned k = 0; k < LPM_SIZE; k++) begin
      if (bus.sel == LPM_WIDTHS'(k)) begin
        mux_value = bus.data[k*LPM_WIDTH +: LPM_WIDTH];
        mux_err   = 1'b0;
      end
    end
  end

  generate
    if (LPM_PIPELINE == 0) begin : g_comb
      logic unused_clk_ctrl;

      assign unused_clk_ctrl = ^{clock, aclr_n, clken};
      assign bus.result      = mux_value;
      assign bus.sel_err     = mux_err;
      assign bus.out_valid   = bus.in_valid;
      assign bus.in_ready    = bus.out_ready;
      assign bus.occupancy   = '0;
    end else begin : g_pipe
      localparam int P = LPM_PIPELINE;

      logic [P-1:0]  valid;
      logic [P-1:0]  up_valid;
      logic [PW-1:0] up_payload [P];
      logic [PW-1:0] payload    [P];
      logic [P:0]    adv;
      logic          accept;
      logic          drain;
      logic [OW-1:0] occ;

      // advance_i unrolled: stage i moves unless it and everything below is full
      // and the consumer stalls. Flattening keeps the chain free of comb loops.
      assign adv[P] = bus.out_ready;

      for (genvar i = 0; i < P; i++) begin : g_stage
        assign adv[i] = bus.out_ready || !(&valid[P-1:i]);

        if (i == 0) begin : g_head
          assign up_valid[i]   = accept;
          assign up_payload[i] = {mux_err, mux_value};
        end else begin : g_body
          assign up_valid[i]   = valid[i-1];
          assign up_payload[i] = payload[i-1];
        end

        lpm_elastic_stage #(
          .WIDTH (PW)
        ) u_stage (
          .clock        (clock),
          .aclr_n       (aclr_n),
          .clken        (clken),
          .up_valid     (up_valid[i]),
          .up_payload   (up_payload[i]),
          .down_advance (adv[i+1]),
          .valid        (valid[i]),
          .payload      (payload[i])
        );
      end

      assign bus.in_ready  = adv[0] && clken;
      assign accept        = bus.in_valid && bus.in_ready;
      assign drain         = valid[P-1] && bus.out_ready;

      // Net change in full stages is exactly accepts minus drains per enabled edge.
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          occ <= '0;
        end else if (clken) begin
          occ <= occ + OW'(accept) - OW'(drain);
        end
      end

      assign bus.result    = payload[P-1][LPM_WIDTH-1:0];
      assign bus.sel_err   = payload[P-1][LPM_WIDTH];
      assign bus.out_valid = valid[P-1];
      assign bus.occupancy = occ;
    end
  endgenerate

endmodule

// File: tb/tb_lpm_mux_elastic.sv
// Directed bench for lpm_mux_elastic: four configurations (P=2, OOR P=2, P=0, P=3)
// driven by one shared stimulus set.
module tb_lpm_mux_elastic;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        clken;
  logic [31:0] data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  lpm_mux_elastic_if #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(2)) if_a ();
  lpm_mux_elastic_if #(.LPM_WIDTH(8), .LPM_SIZE(3), .LPM_WIDTHS(2), .LPM_PIPELINE(2)) if_b ();
  lpm_mux_elastic_if #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(0)) if_c ();
  lpm_mux_elastic_if #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(3)) if_d ();

  assign if_a.data = data;        assign if_a.sel = sel;
  assign if_a.in_valid = in_valid; assign if_a.out_ready = out_ready;
  assign if_b.data = data[23:0];  assign if_b.sel = sel;
  assign if_b.in_valid = in_valid; assign if_b.out_ready = out_ready;
  assign if_c.data = data;        assign if_c.sel = sel;
  assign if_c.in_valid = in_valid; assign if_c.out_ready = out_ready;
  assign if_d.data = data;        assign if_d.sel = sel;
  assign if_d.in_valid = in_valid; assign if_d.out_ready = out_ready;

  lpm_mux_elastic #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(2), .OOR_VALUE(8'h00))
    u_dut_a (.clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(if_a));
  lpm_mux_elastic #(.LPM_WIDTH(8), .LPM_SIZE(3), .LPM_WIDTHS(2), .LPM_PIPELINE(2), .OOR_VALUE(8'hEE))
    u_dut_b (.clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(if_b));
  lpm_mux_elastic #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(0), .OOR_VALUE(8'h00))
    u_dut_c (.clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(if_c));
  lpm_mux_elastic #(.LPM_WIDTH(8), .LPM_SIZE(4), .LPM_WIDTHS(2), .LPM_PIPELINE(3), .OOR_VALUE(8'h00))
    u_dut_d (.clock(clock), .aclr_n(aclr_n), .clken(clken), .bus(if_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int rcv;

    // Reset with random inputs
    aclr_n    = 1'b0;
    clken     = 1'b1;
    data      = $urandom;
    sel       = 2'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_occupancy", 32'(if_a.occupancy), 32'd0);
    check("rst_result",    32'(if_a.result),    32'd0);
    check("rst_sel_err",   32'(if_a.sel_err),   32'd0);
    check("rst_occ_d",     32'(if_d.occupancy), 32'd0);
    aclr_n   = 1'b1;
    in_valid = 1'b0;
    data     = 32'h44332211;
    #1;
    check("rel_in_ready", 32'(if_a.in_ready), 32'd1);

    // Basic select, latency 2
    tick();
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("lat_early_valid", 32'(if_a.out_valid), 32'd0);
    check("lat_early_occ",   32'(if_a.occupancy), 32'd1);
    tick();
    #1;
    check("sel2_valid",  32'(if_a.out_valid), 32'd1);
    check("sel2_result", 32'(if_a.result),    32'h33);
    check("sel2_err",    32'(if_a.sel_err),   32'd0);
    tick();
    #1;
    check("sel2_gone", 32'(if_a.out_valid), 32'd0);

    // Out-of-range select on the 3-input instance
    sel = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("oor_valid",    32'(if_b.out_valid), 32'd1);
    check("oor_result",   32'(if_b.result),    32'hEE);
    check("oor_err",      32'(if_b.sel_err),   32'd1);
    check("sel3_result",  32'(if_a.result),    32'h44);
    check("sel3_err",     32'(if_a.sel_err),   32'd0);

    // Combinational pass-through (P=0), all within one cycle
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("p0_result",   32'(if_c.result),    32'h22);
    check("p0_valid",    32'(if_c.out_valid), 32'd1);
    check("p0_ready_lo", 32'(if_c.in_ready),  32'd0);
    check("p0_occ",      32'(if_c.occupancy), 32'd0);
    out_ready = 1'b1;
    #1;
    check("p0_ready_hi", 32'(if_c.in_ready),  32'd1);
    in_valid = 1'b0;
    repeat (4) tick();

    // Backpressure: four items, consumer stalled for 4 cycles
    data = 32'hA3A2A1A0;
    idx  = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 4);
      sel       = 2'(idx);
      #1;
      if (cyc == 2 || cyc == 3) begin
        check("bp_in_ready", 32'(if_a.in_ready),  32'd0);
        check("bp_occ",      32'(if_a.occupancy), 32'd2);
        check("bp_hold",     32'(if_a.result),    32'hA0);
      end
      if (if_a.out_valid && out_ready) begin
        check("bp_order", 32'(if_a.result), 32'hA0 + 32'(rcv));
        rcv++;
      end
      if (in_valid && if_a.in_ready) idx++;
      tick();
    end
    check("bp_sent", 32'(idx), 32'd4);
    check("bp_rcvd", 32'(rcv), 32'd4);

    // Bubble collapse, then clock-enable freeze
    data = 32'h44332211;
    sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("bub_occ1",   32'(if_a.occupancy), 32'd1);
    check("bub_result", 32'(if_a.result),    32'h11);
    in_valid = 1'b1; sel = 2'd3;
    #1;
    check("bub_ready", 32'(if_a.in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bub_occ2",  32'(if_a.occupancy), 32'd2);
    check("full_ready", 32'(if_a.in_ready), 32'd0);
    clken = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("ce_in_ready", 32'(if_a.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("ce_occ",    32'(if_a.occupancy), 32'd2);
      check("ce_result", 32'(if_a.result),    32'h11);
      check("ce_valid",  32'(if_a.out_valid), 32'd1);
    end
    clken = 1'b1; in_valid = 1'b0;
    tick();
    #1;
    check("ce_next",     32'(if_a.result),    32'h44);
    check("ce_next_occ", 32'(if_a.occupancy), 32'd1);
    tick();
    #1;
    check("ce_empty", 32'(if_a.occupancy), 32'd0);
    repeat (3) tick();

    // Mid-stream reset on the 3-stage instance
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    repeat (3) tick();
    #1;
    check("d_full_occ",   32'(if_d.occupancy), 32'd3);
    check("d_full_ready", 32'(if_d.in_ready),  32'd0);
    check("d_full_valid", 32'(if_d.out_valid), 32'd1);
    aclr_n = 1'b0;
    #1;
    check("d_rst_occ",    32'(if_d.occupancy), 32'd0);
    check("d_rst_valid",  32'(if_d.out_valid), 32'd0);
    check("d_rst_result", 32'(if_d.result),    32'd0);
    aclr_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("d_no_stale", 32'(if_d.out_valid), 32'd0);
    end
    sel = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("d_lat_early", 32'(if_d.out_valid), 32'd0);
    tick();
    #1;
    check("d_lat_valid",  32'(if_d.out_valid), 32'd1);
    check("d_lat_result", 32'(if_d.result),    32'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
